mem_bus_arbiter: RTL

//  Shares the single-port SOC Memory between two bus masters: M0 = Processor, M1 = UART loader/debug port.

---
 rtl/soc_bus_pkg.sv | 22 ++
 rtl/rr_pick2.sv | 29 ++
 rtl/mem_bus_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/soc_bus_pkg.sv
// Shared types and constants for the SOC memory bus arbiter.
// Holds the arbiter FSM encoding, master indices and bus widths.
package soc_bus_pkg;

  localparam int DATA_W  = 32;
  localparam int WMASK_W = 4;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } bus_state_t;

  // A master requests on a read pulse or any nonzero byte-write mask.
  function automatic logic is_strobe(input logic rstrb, input logic [WMASK_W-1:0] wmask);
    return rstrb | (|wmask);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way grant picker: single requester wins outright, ties go to the
// master not served last, or always to M0 when fixed priority is selected.
module rr_pick2
  import soc_bus_pkg::*;
(
  input  logic pend0,
  input  logic pend1,
  input  logic last,
  input  logic fixed,
  output logic gnt
);

  // Grant selection
  always_comb begin
    gnt = M0;
    if (pend0 && pend1) begin
      if (fixed) begin
        gnt = M0;
      end else begin
        gnt = ~last;
      end
    end else if (pend1) begin
      gnt = M1;
    end else begin
      gnt = M0;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares a single-port registered-read memory between two strobe-style masters,
// issuing one registered memory cycle per request and a one-cycle ready pulse back.
module mem_bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [WMASK_W-1:0]    m0_wmask,
  input  logic                  m0_rstrb,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic                  m0_ready,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [WMASK_W-1:0]    m1_wmask,
  input  logic                  m1_rstrb,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  m1_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [WMASK_W-1:0]    mem_wmask,
  output logic                  mem_rstrb,
  input  logic [DATA_W-1:0]     mem_rdata
);

  bus_state_t state_r;
  logic       pend0_r, pend1_r, last_r, gnt_r, ready0_r, ready1_r;
  logic [WMASK_W-1:0] pmask0_r, pmask1_r;

  logic strobe0_s, strobe1_s, req0_s, req1_s, gnt_s, issue_s;
  logic [WMASK_W-1:0]    req_mask0_s, req_mask1_s, gmask_s;
  logic [ADDR_WIDTH-1:0] gaddr_s;
  logic [DATA_W-1:0]     gwdata_s;

  // A fresh strobe counts as a request in the same cycle, so an idle or
  // completing arbiter issues without first parking it in the pending flag.
  always_comb begin
    strobe0_s = is_strobe(m0_rstrb, m0_wmask);
    strobe1_s = is_strobe(m1_rstrb, m1_wmask);
    req0_s    = pend0_r | strobe0_s;
    req1_s    = pend1_r | strobe1_s;
    if (pend0_r) begin
      req_mask0_s = pmask0_r;
    end else begin
      req_mask0_s = m0_wmask;
    end
    if (pend1_r) begin
      req_mask1_s = pmask1_r;
    end else begin
      req_mask1_s = m1_wmask;
    end
    issue_s = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && (req0_s || req1_s);
  end

  rr_pick2 u_pick (
    .pend0 (req0_s),
    .pend1 (req1_s),
    .last  (last_r),
    .fixed (FIXED_PRIORITY),
    .gnt   (gnt_s)
  );

  // Mux the granted master's request onto the issue path
  always_comb begin
    if (gnt_s == M1) begin
      gaddr_s  = m1_addr;
      gwdata_s = m1_wdata;
      gmask_s  = req_mask1_s;
    end else begin
      gaddr_s  = m0_addr;
      gwdata_s = m0_wdata;
      gmask_s  = req_mask0_s;
    end
  end

  // Pending flags: cleared when granted, strobes while already pending are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      pend0_r  <= 1'b0;
      pend1_r  <= 1'b0;
      pmask0_r <= {WMASK_W{1'b0}};
      pmask1_r <= {WMASK_W{1'b0}};
    end else begin
      if (issue_s && (gnt_s == M0)) begin
        pend0_r <= 1'b0;
      end else if (!pend0_r && strobe0_s) begin
        pend0_r  <= 1'b1;
        pmask0_r <= m0_wmask;
      end
      if (issue_s && (gnt_s == M1)) begin
        pend1_r <= 1'b0;
      end else if (!pend1_r && strobe1_s) begin
        pend1_r  <= 1'b1;
        pmask1_r <= m1_wmask;
      end
    end
  end

  // Arbiter FSM with registered memory strobes and ready pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      last_r    <= 1'b1;
      gnt_r     <= M0;
      ready0_r  <= 1'b0;
      ready1_r  <= 1'b0;
      mem_addr  <= {ADDR_WIDTH{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      mem_wmask <= {WMASK_W{1'b0}};
      mem_rstrb <= 1'b0;
    end else begin
      ready0_r  <= 1'b0;
      ready1_r  <= 1'b0;
      mem_wmask <= {WMASK_W{1'b0}};
      mem_rstrb <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (issue_s) begin
            state_r   <= ST_ISSUE;
            gnt_r     <= gnt_s;
            last_r    <= gnt_s;
            mem_addr  <= gaddr_s;
            mem_wdata <= gwdata_s;
            mem_wmask <= gmask_s;
            mem_rstrb <= ~(|gmask_s);
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          state_r <= ST_DONE;
          if (gnt_r == M1) begin
            ready1_r <= 1'b1;
          end else begin
            ready0_r <= 1'b1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Memory read data is only routed to the master whose ready is pulsing
  always_comb begin
    m0_ready = ready0_r;
    m1_ready = ready1_r;
    if (ready0_r) begin
      m0_rdata = mem_rdata;
    end else begin
      m0_rdata = {DATA_W{1'b0}};
    end
    if (ready1_r) begin
      m1_rdata = mem_rdata;
    end else begin
      m1_rdata = {DATA_W{1'b0}};
    end
  end

endmodule
